// File: rtl/dma_mc_engine_pkg.sv
// Shared types and default widths for the multi-channel DMA engine.
package dma_pkg_hdl;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_NUM_CH     = 4;
    localparam int DEF_LEN_WIDTH  = 8;
    localparam int DEF_RD_LATENCY = 1;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        RD,
        WAIT,
        WR
    } dma_eng_state_t;

    typedef struct packed {
        logic [DEF_ADDR_WIDTH-1:0] src;
        logic [DEF_ADDR_WIDTH-1:0] dst;
        logic [DEF_LEN_WIDTH-1:0]  len;
    } dma_desc_t;

endpackage

// File: rtl/dma_mc_engine_if.sv
// Memory-side bus of the DMA engine; the engine is the master and the memory is the slave.
interface dma_mc_engine_if
    import dma_pkg_hdl::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

    logic                  rd_en;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (output rd_en, output wr_en, output addr, output wdata, input rdata);
    modport slave  (input rd_en, input wr_en, input addr, input wdata, output rdata);

endinterface

// File: rtl/dma_mc_engine_rr_arbiter.sv
// Round-robin arbiter: the search starts one past the last granted channel.
module dma_rr_arbiter
    import dma_pkg_hdl::*;
#(
    parameter int NUM_CH = DEF_NUM_CH
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         req,
    input  logic                      update,
    output logic [$clog2(NUM_CH)-1:0] grant,
    output logic                      grant_valid
);

    localparam int CH_W = $clog2(NUM_CH);

    logic [CH_W-1:0] ptr_q, ptr_d;
    logic [CH_W-1:0] idx;

    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        idx         = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = CH_W'((int'(ptr_q) + i) % NUM_CH);
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant       = idx;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (update && grant_valid) begin
            if (int'(grant) == NUM_CH - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/dma_mc_engine.sv
// Multi-channel DMA engine: per-channel descriptors, one word copied per round-robin grant.
module dma_mc_engine
    import dma_pkg_hdl::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
    parameter int RD_LATENCY = DEF_RD_LATENCY
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
    input  logic [ADDR_WIDTH-1:0]     cfg_src,
    input  logic [ADDR_WIDTH-1:0]     cfg_dst,
    input  logic [LEN_WIDTH-1:0]      cfg_len,
    dma_mc_engine_if.master           bus,
    output logic [NUM_CH-1:0]         busy,
    output logic [NUM_CH-1:0]         done
);

    localparam int CH_W   = $clog2(NUM_CH);
    localparam int WAIT_W = $clog2(RD_LATENCY) + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] src;
        logic [ADDR_WIDTH-1:0] dst;
        logic [LEN_WIDTH-1:0]  len;
    } chan_desc_t;

    dma_eng_state_t        state_q, state_d;
    chan_desc_t            desc_q [NUM_CH];
    chan_desc_t            desc_d [NUM_CH];
    logic [NUM_CH-1:0]     busy_q, busy_d;
    logic [NUM_CH-1:0]     done_q, done_d;
    logic [CH_W-1:0]       grant_q, grant_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic                  rd_en_o, wr_en_o, arb_update;
    logic [ADDR_WIDTH-1:0] addr_o;
    logic [DATA_WIDTH-1:0] wdata_o;
    logic [CH_W-1:0]       arb_grant;
    logic                  arb_valid;
    logic                  accept;

    dma_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .clock       (clock),
        .reset       (reset),
        .req         (busy_q),
        .update      (arb_update),
        .grant       (arb_grant),
        .grant_valid (arb_valid)
    );

    assign cfg_ready = !busy_q[cfg_ch];
    assign accept    = cfg_valid && cfg_ready;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|busy_q) state_d = ARB;
            ARB:     state_d = RD;
            RD:      state_d = WAIT;
            WAIT:    if (wait_q == '0) state_d = WR;
            WR:      state_d = (|busy_d) ? ARB : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outside RD/WR the bus address and write data keep their last driven values.
    always_comb begin
        rd_en_o    = 1'b0;
        wr_en_o    = 1'b0;
        arb_update = 1'b0;
        addr_o     = addr_q;
        wdata_o    = wdata_q;
        case (state_q)
            ARB: arb_update = 1'b1;
            RD: begin
                rd_en_o = 1'b1;
                addr_o  = desc_q[grant_q].src;
            end
            WR: begin
                wr_en_o = 1'b1;
                addr_o  = desc_q[grant_q].dst;
                wdata_o = data_q;
            end
            default: ;
        endcase
    end

    // A busy channel cannot be reconfigured, so cfg writes and WR updates never hit the same channel.
    always_comb begin
        desc_d  = desc_q;
        busy_d  = busy_q;
        done_d  = '0;
        grant_d = grant_q;
        data_d  = data_q;
        wait_d  = wait_q;
        addr_d  = addr_o;
        wdata_d = wdata_o;
        if (accept) begin
            desc_d[cfg_ch] = '{src: cfg_src, dst: cfg_dst, len: cfg_len};
            if (cfg_len == '0) begin
                done_d[cfg_ch] = 1'b1;
            end else begin
                busy_d[cfg_ch] = 1'b1;
            end
        end
        case (state_q)
            ARB: if (arb_valid) grant_d = arb_grant;
            RD:  wait_d = WAIT_W'(RD_LATENCY - 1);
            WAIT: begin
                if (wait_q == '0) begin
                    data_d = bus.rdata;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            WR: begin
                desc_d[grant_q].src = desc_q[grant_q].src + 1'b1;
                desc_d[grant_q].dst = desc_q[grant_q].dst + 1'b1;
                desc_d[grant_q].len = desc_q[grant_q].len - 1'b1;
                if (desc_q[grant_q].len == LEN_WIDTH'(1)) begin
                    busy_d[grant_q] = 1'b0;
                    done_d[grant_q] = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                desc_q[i] <= '0;
            end
            busy_q  <= '0;
            done_q  <= '0;
            grant_q <= '0;
            data_q  <= '0;
            wait_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            desc_q  <= desc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            wait_q  <= wait_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.rd_en = rd_en_o;
    assign bus.wr_en = wr_en_o;
    assign bus.addr  = addr_o;
    assign bus.wdata = wdata_o;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_dma_mc_engine.sv
// Directed bench for dma_mc_engine: memory model on the bus, negedge bus monitor, hand-computed expectations.
module tb_dma_mc_engine;

    logic       clock = 1'b0;
    logic       reset;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_src;
    logic [7:0] cfg_dst;
    logic [7:0] cfg_len;
    logic [3:0] busy;
    logic [3:0] done;

    logic        pre_we;
    logic [7:0]  pre_addr;
    logic [15:0] pre_data;
    logic [15:0] mem [256];

    int cyc = 0;
    int nCompared = 0;
    int nMismatched = 0;
    logic overlap = 1'b0;

    logic [7:0]  rd_addrs [$];
    logic [7:0]  wr_addrs [$];
    logic [15:0] wr_datas [$];
    int          wr_cycs  [$];
    logic [3:0]  done_vecs [$];
    int          done_cycs [$];
    int br, bw, bd;

    dma_mc_engine_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) bus ();

    dma_mc_engine #(
        .DATA_WIDTH(16), .ADDR_WIDTH(8), .NUM_CH(4), .LEN_WIDTH(8), .RD_LATENCY(1)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_src   (cfg_src),
        .cfg_dst   (cfg_dst),
        .cfg_len   (cfg_len),
        .bus       (bus),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Single-port memory with one cycle of read latency; preload only while the bus is quiet.
    always @(posedge clock) begin
        if (bus.rd_en) bus.rdata <= mem[bus.addr];
        if (bus.wr_en) mem[bus.addr] <= bus.wdata;
        else if (pre_we) mem[pre_addr] <= pre_data;
    end

    always @(negedge clock) begin
        if (bus.rd_en) rd_addrs.push_back(bus.addr);
        if (bus.wr_en) begin
            wr_addrs.push_back(bus.addr);
            wr_datas.push_back(bus.wdata);
            wr_cycs.push_back(cyc);
        end
        if (|done) begin
            done_vecs.push_back(done);
            done_cycs.push_back(cyc);
        end
        if (bus.rd_en && bus.wr_en) overlap <= 1'b1;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [31:0] getRd(input int i);
        return (br + i < rd_addrs.size()) ? 32'(rd_addrs[br + i]) : 32'hFFFF_FFFF;
    endfunction
    function automatic logic [31:0] getWa(input int i);
        return (bw + i < wr_addrs.size()) ? 32'(wr_addrs[bw + i]) : 32'hFFFF_FFFF;
    endfunction
    function automatic logic [31:0] getWd(input int i);
        return (bw + i < wr_datas.size()) ? 32'(wr_datas[bw + i]) : 32'hFFFF_FFFF;
    endfunction
    function automatic int getWc(input int i);
        return (bw + i < wr_cycs.size()) ? wr_cycs[bw + i] : -100;
    endfunction
    function automatic logic [31:0] getDv(input int i);
        return (bd + i < done_vecs.size()) ? 32'(done_vecs[bd + i]) : 32'hFFFF_FFFF;
    endfunction
    function automatic int getDc(input int i);
        return (bd + i < done_cycs.size()) ? done_cycs[bd + i] : -100;
    endfunction

    task automatic mark();
        br = rd_addrs.size();
        bw = wr_addrs.size();
        bd = done_vecs.size();
    endtask

    task automatic preload(input logic [7:0] a, input logic [15:0] d);
        @(negedge clock);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clock);
        pre_we = 1'b0;
    endtask

    task automatic applyStimulus(input logic [1:0] ch, input logic [7:0] src, input logic [7:0] dst,
                                 input logic [7:0] len, output logic rdy, output int c);
        @(negedge clock);
        cfg_valid = 1'b1; cfg_ch = ch; cfg_src = src; cfg_dst = dst; cfg_len = len;
        c = cyc;
        #1 rdy = cfg_ready;
    endtask

    task automatic cfgIdle();
        @(negedge clock);
        cfg_valid = 1'b0;
    endtask

    task automatic waitIdle(input int maxc);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (busy != 4'b0 && n < maxc);
        checkOutput("idle_timeout", 32'(n >= maxc), 32'd0);
        repeat (2) @(negedge clock);
    endtask

    initial begin
        logic rdy;
        int   c;
        int   n;
        logic [7:0]  exp_ra [4];
        logic [7:0]  exp_wa [4];
        logic [15:0] exp_wd [4];

        reset = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_src = '0; cfg_dst = '0; cfg_len = '0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        repeat (3) @(negedge clock);
        checkOutput("rst_strobes", 32'({bus.rd_en, bus.wr_en, busy, done}), 32'd0);
        checkOutput("rst_addr", 32'(bus.addr), 32'd0);
        checkOutput("rst_wdata", 32'(bus.wdata), 32'd0);
        checkOutput("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        reset = 1'b1;

        // Test 1: single channel, three words
        preload(8'h10, 16'h00A1); preload(8'h11, 16'h00B2); preload(8'h12, 16'h00C3);
        mark();
        applyStimulus(2'd0, 8'h10, 8'h80, 8'd3, rdy, c);
        cfgIdle();
        checkOutput("t1_busy", 32'(busy), 32'h1);
        waitIdle(100);
        exp_ra = '{8'h10, 8'h11, 8'h12, 8'h00};
        exp_wa = '{8'h80, 8'h81, 8'h82, 8'h00};
        exp_wd = '{16'h00A1, 16'h00B2, 16'h00C3, 16'h0};
        checkOutput("t1_rd_count", 32'(rd_addrs.size() - br), 32'd3);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("t1_rd_addr%0d", i), getRd(i), 32'(exp_ra[i]));
            checkOutput($sformatf("t1_wr_addr%0d", i), getWa(i), 32'(exp_wa[i]));
            checkOutput($sformatf("t1_wr_data%0d", i), getWd(i), 32'(exp_wd[i]));
        end
        checkOutput("t1_word_period", 32'(getWc(2) - getWc(1)), 32'd4);
        checkOutput("t1_done_vec", getDv(0), 32'h1);
        checkOutput("t1_done_cyc", 32'(getDc(0)), 32'(getWc(2) + 1));
        checkOutput("t1_done_count", 32'(done_vecs.size() - bd), 32'd1);

        // Test 2: two channels interleave under round-robin
        preload(8'h20, 16'h1111); preload(8'h21, 16'h2222);
        preload(8'h30, 16'h3333); preload(8'h31, 16'h4444);
        mark();
        applyStimulus(2'd1, 8'h20, 8'h90, 8'd2, rdy, c);
        applyStimulus(2'd2, 8'h30, 8'hA0, 8'd2, rdy, c);
        cfgIdle();
        waitIdle(100);
        exp_ra = '{8'h20, 8'h30, 8'h21, 8'h31};
        exp_wa = '{8'h90, 8'hA0, 8'h91, 8'hA1};
        exp_wd = '{16'h1111, 16'h3333, 16'h2222, 16'h4444};
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("t2_rd_addr%0d", i), getRd(i), 32'(exp_ra[i]));
            checkOutput($sformatf("t2_wr_addr%0d", i), getWa(i), 32'(exp_wa[i]));
            checkOutput($sformatf("t2_wr_data%0d", i), getWd(i), 32'(exp_wd[i]));
        end
        checkOutput("t2_done_vec0", getDv(0), 32'h2);
        checkOutput("t2_done_vec1", getDv(1), 32'h4);
        checkOutput("t2_done_gap", 32'(getDc(1) - getDc(0)), 32'd4);

        // Test 3: zero-length descriptor completes without bus traffic
        mark();
        applyStimulus(2'd3, 8'h00, 8'h00, 8'd0, rdy, c);
        checkOutput("t3_cfg_ready", 32'(rdy), 32'd1);
        cfgIdle();
        checkOutput("t3_busy", 32'(busy), 32'd0);
        repeat (4) @(negedge clock);
        checkOutput("t3_done_count", 32'(done_vecs.size() - bd), 32'd1);
        checkOutput("t3_done_vec", getDv(0), 32'h8);
        checkOutput("t3_done_cyc", 32'(getDc(0)), 32'(c + 1));
        checkOutput("t3_bus_quiet", 32'((rd_addrs.size() - br) + (wr_addrs.size() - bw)), 32'd0);

        // Tests 4/5: address wrap plus an ignored reconfiguration of the busy channel
        preload(8'hFE, 16'h5A5A);
        mark();
        applyStimulus(2'd0, 8'hFE, 8'hFF, 8'd4, rdy, c);
        cfgIdle();
        repeat (5) @(negedge clock);
        applyStimulus(2'd0, 8'h40, 8'h50, 8'd7, rdy, c);
        checkOutput("t5_cfg_ready_busy", 32'(rdy), 32'd0);
        cfgIdle();
        waitIdle(200);
        repeat (10) @(negedge clock);
        exp_ra = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        exp_wa = '{8'hFF, 8'h00, 8'h01, 8'h02};
        checkOutput("t4_rd_count", 32'(rd_addrs.size() - br), 32'd4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("t4_rd_addr%0d", i), getRd(i), 32'(exp_ra[i]));
            checkOutput($sformatf("t4_wr_addr%0d", i), getWa(i), 32'(exp_wa[i]));
            checkOutput($sformatf("t4_wr_data%0d", i), getWd(i), 32'h5A5A);
        end
        checkOutput("t4_done_vec", getDv(0), 32'h1);
        checkOutput("t4_busy_after", 32'(busy), 32'd0);

        // Test 6: reset during WAIT aborts silently and restores ch0-first priority
        preload(8'h60, 16'h6060);
        mark();
        applyStimulus(2'd1, 8'h60, 8'hC0, 8'd3, rdy, c);
        cfgIdle();
        n = 0;
        while (!bus.rd_en && n < 50) begin
            @(negedge clock);
            n++;
        end
        checkOutput("t6_rd_timeout", 32'(n >= 50), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("t6_rst_strobes", 32'({bus.rd_en, bus.wr_en, busy, done}), 32'd0);
        checkOutput("t6_rst_addr", 32'(bus.addr), 32'd0);
        checkOutput("t6_rst_wdata", 32'(bus.wdata), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        repeat (8) @(negedge clock);
        checkOutput("t6_no_done", 32'(done_vecs.size() - bd), 32'd0);
        checkOutput("t6_no_write", 32'(wr_addrs.size() - bw), 32'd0);
        preload(8'h70, 16'h7070); preload(8'h78, 16'h7878);
        mark();
        applyStimulus(2'd3, 8'h70, 8'hB0, 8'd1, rdy, c);
        applyStimulus(2'd1, 8'h78, 8'hB8, 8'd1, rdy, c);
        cfgIdle();
        waitIdle(100);
        checkOutput("t6_rd_addr0", getRd(0), 32'h78);
        checkOutput("t6_rd_addr1", getRd(1), 32'h70);
        checkOutput("t6_wr_addr0", getWa(0), 32'hB8);
        checkOutput("t6_wr_data0", getWd(0), 32'h7878);
        checkOutput("t6_wr_addr1", getWa(1), 32'hB0);
        checkOutput("t6_wr_data1", getWd(1), 32'h7070);
        checkOutput("t6_done_count", 32'(done_vecs.size() - bd), 32'd2);

        checkOutput("rd_wr_exclusive", 32'(overlap), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
